// File: rtl/nios_lcd_ctrl_if.sv
// Avalon-MM write-side slave bus for the HD44780 LCD controller.
// The CPU side drives the master modport; nios_lcd_ctrl connects to slave.
interface nios_lcd_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_lcd_ctrl.sv
// HD44780 8-bit write-only LCD driver behind an Avalon-MM slave; busy paces firmware.
// Define NIOS_LCD_CTRL_FIFO_EN to add a 4-entry request FIFO ahead of the FSM.
module nios_lcd_ctrl #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned EN_CYCLES    = 12,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned CMD_WAIT     = 2000,
  parameter int unsigned CLEAR_WAIT   = 82000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_lcd_ctrl_if.slave        avs,
  output logic [7:0]            lcd_data,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_en,
  output logic                  busy
);

  localparam logic [16:0] SETUP_LD = 17'(SETUP_CYCLES - 1);
  localparam logic [16:0] EN_LD    = 17'(EN_CYCLES - 1);
  localparam logic [16:0] HOLD_LD  = 17'(HOLD_CYCLES - 1);
  localparam logic [16:0] CMD_LD   = 17'(CMD_WAIT - 1);
  localparam logic [16:0] CLEAR_LD = 17'(CLEAR_WAIT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  state_t      state;
  logic [16:0] cnt;
  logic        overflow;
  logic [31:0] readdata_q;

  logic        wr_strobe;
  logic        req;
  logic [8:0]  req_entry;
  logic        ovf_clr;
  logic        retire;
  logic        is_clear;
  logic        unused_wdata;

  // Request-store view shared with the FSM
  logic        empty;
  logic        push;
  logic        has_next;
  logic        occ_next;
  logic [8:0]  head;
  logic [8:0]  next_entry;

  assign wr_strobe    = avs.chipselect & ~avs.write_n;
  assign req          = wr_strobe & ~avs.address[1];
  assign req_entry    = {avs.address[0], avs.writedata[7:0]};
  assign ovf_clr      = wr_strobe & (avs.address == 2'd2) & avs.writedata[1];
  assign retire       = (state == WAIT) && (cnt == '0);
  assign is_clear     = !lcd_rs && (lcd_data inside {8'h01, 8'h02, 8'h03});
  assign unused_wdata = &{1'b0, avs.writedata[31:8], avs.writedata[0]};
  assign lcd_rw       = 1'b0;
  assign avs.readdata = readdata_q;

  // The head entry stays stored while it is on the LCD and is retired when
  // WAIT expires, so the in-flight byte occupies a slot and a queued byte can
  // go straight from WAIT into SETUP.
`ifdef NIOS_LCD_CTRL_FIFO_EN
  logic [8:0] mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;
  logic [2:0] count_next;

  always_comb begin
    push       = req && ((count != 3'd4) || retire);
    empty      = (count == 3'd0);
    has_next   = (count >= 3'd2);
    head       = mem[rd_ptr];
    next_entry = mem[rd_ptr + 2'd1];
    count_next = count + 3'(push) - 3'(retire);
    occ_next   = (count_next != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= req_entry;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (retire) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count_next;
    end
  end
`else
  logic       ent_valid;
  logic [8:0] ent;

  always_comb begin
    push       = req && !ent_valid;
    empty      = !ent_valid;
    has_next   = 1'b0;
    head       = ent;
    next_entry = ent;
    occ_next   = push || (ent_valid && !retire);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ent_valid <= 1'b0;
      ent       <= '0;
    end else if (push) begin
      ent_valid <= 1'b1;
      ent       <= req_entry;
    end else if (retire) begin
      ent_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lcd_data   <= '0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      readdata_q <= '0;
    end else begin
      busy <= occ_next;

      if (req && !push) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      readdata_q <= (avs.address == 2'd2) ? {30'b0, overflow, busy} : '0;

      case (state)
        IDLE: begin
          if (!empty) begin
            {lcd_rs, lcd_data} <= head;
            cnt                <= SETUP_LD;
            state              <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= EN_LD;
            state  <= PULSE;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_clear ? CLEAR_LD : CMD_LD;
            state <= WAIT;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (has_next) begin
              {lcd_rs, lcd_data} <= next_entry;
              cnt                <= SETUP_LD;
              state              <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_lcd_ctrl.sv
// Self-checking bench for nios_lcd_ctrl: directed scenarios with timing constants
// plus randomized traffic against a transfer-schedule reference model.
module tb_nios_lcd_ctrl;
  localparam int SU   = 2;
  localparam int EN   = 12;
  localparam int HO   = 2;
  localparam int CW   = 20;
  localparam int CLW  = 100;
  localparam int NORM = 1 + SU + EN + HO + CW;
  localparam int CLR  = 1 + SU + EN + HO + CLW;
`ifdef NIOS_LCD_CTRL_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, busy;

  nios_lcd_ctrl_if bus ();

  nios_lcd_ctrl #(.CMD_WAIT(CW), .CLEAR_WAIT(CLW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: each accepted byte is one scheduled transfer
  // (accept edge a, data-valid edge s, idle edge e).
  typedef struct {
    int         a;
    int         s;
    int         e;
    logic       rs;
    logic [7:0] b;
  } xfer_t;

  xfer_t       xq[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_rd  = '0;

  function automatic logic m_busy(input int n);
    foreach (xq[i]) if (xq[i].a <= n && n < xq[i].e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_en(input int n);
    foreach (xq[i]) if (xq[i].s + SU <= n && n < xq[i].s + SU + EN) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] m_out(input int n);
    logic [8:0] r = '0;
    foreach (xq[i]) if (xq[i].s <= n) r = {xq[i].rs, xq[i].b};
    return r;
  endfunction

  task automatic step(input bit rst, input bit cs, input bit wn,
                      input logic [1:0] ad, input logic [31:0] wd);
    int    occ;
    bit    ret;
    bit    acc;
    xfer_t x;
    reset_n        = !rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = ad;
    bus.writedata  = wd;
    @(posedge clk);
    cyc++;
    if (rst) begin
      xq.delete();
      m_ovf = 1'b0;
      m_rd  = '0;
    end else begin
      m_rd = (ad == 2'd2) ? {30'b0, m_ovf, m_busy(cyc - 1)} : 32'h0;
      if (cs && !wn && ad < 2'd2) begin
        occ = 0;
        ret = 1'b0;
        foreach (xq[i]) begin
          if (xq[i].a < cyc && cyc <= xq[i].e) occ++;
          if (xq[i].e == cyc) ret = 1'b1;
        end
        acc = FIFO ? (occ < 4 || ret) : (occ == 0);
        if (acc) begin
          x.a  = cyc;
          x.rs = ad[0];
          x.b  = wd[7:0];
          x.s  = cyc + 1;
          if (xq.size() > 0 && xq[$].e > x.s) x.s = xq[$].e;
          x.e  = x.s + SU + EN + HO +
                 ((!x.rs && x.b >= 8'h01 && x.b <= 8'h03) ? CLW : CW);
          xq.push_back(x);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (cs && !wn && ad == 2'd2 && wd[1]) begin
        m_ovf = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 1, 2'd0, '0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 2'd0, '0);
      total++;
      if ({lcd_data, lcd_rs, lcd_rw, lcd_en, busy} !== 12'h0)
        $display("FAIL reset_outputs cyc=%0d got data=%h rs=%b rw=%b en=%b busy=%b required all 0",
                 cyc, lcd_data, lcd_rs, lcd_rw, lcd_en, busy);
      else passed++;
    end
    step(0, 1, 1, 2'd2, '0);
    total++;
    if (bus.readdata !== 32'h0)
      $display("FAIL reset_status got %h required 0", bus.readdata);
    else passed++;
  endtask

  task automatic test_byte(input string nm, input logic [1:0] ad,
                           input logic [7:0] b, input int fall);
    logic exp_en;
    step(0, 1, 0, ad, {24'h0, b});
    for (int k = 1; k <= fall + 1; k++) begin
      step(0, 0, 1, 2'd3, '0);
      exp_en = (k >= 1 + SU) && (k <= SU + EN);
      total++;
      if (lcd_data !== b || lcd_rs !== ad[0])
        $display("FAIL %s_bus k=%0d got rs=%b data=%h required rs=%b data=%h",
                 nm, k, lcd_rs, lcd_data, ad[0], b);
      else passed++;
      total++;
      if (lcd_en !== exp_en)
        $display("FAIL %s_en k=%0d got %b required %b", nm, k, lcd_en, exp_en);
      else passed++;
      total++;
      if (busy !== (k < fall))
        $display("FAIL %s_busy k=%0d got %b required %b", nm, k, busy, k < fall);
      else passed++;
    end
  endtask

`ifndef NIOS_LCD_CTRL_FIFO_EN
  task automatic test_overflow();
    for (int k = 0; k <= 40; k++) begin
      case (k)
        0:       step(0, 1, 0, 2'd1, 32'h41);
        5:       step(0, 1, 0, 2'd1, 32'h42);
        6, 8:    step(0, 1, 1, 2'd2, '0);
        7:       step(0, 1, 0, 2'd2, 32'h2);
        37:      step(0, 1, 0, 2'd1, 32'h43);
        38:      step(0, 1, 1, 2'd2, '0);
        39:      step(0, 1, 0, 2'd2, 32'h2);
        default: step(0, 0, 1, 2'd0, '0);
      endcase
      if (k >= 1) begin
        total++;
        if (lcd_data !== 8'h41 || lcd_rs !== 1'b1)
          $display("FAIL drop_data k=%0d got rs=%b data=%h required rs=1 data=41",
                   k, lcd_rs, lcd_data);
        else passed++;
      end
      if (k == 6 || k == 8 || k == 38) begin
        total++;
        if (bus.readdata !== ((k == 6) ? 32'h3 : (k == 8) ? 32'h1 : 32'h2))
          $display("FAIL drop_status k=%0d got %h required %h", k, bus.readdata,
                   (k == 6) ? 32'h3 : (k == 8) ? 32'h1 : 32'h2);
        else passed++;
      end
    end
  endtask
`else
  task automatic test_fifo_overflow();
    logic [7:0] exp_d;
    for (int k = 0; k <= 150; k++) begin
      if (k <= 4)        step(0, 1, 0, 2'd1, 32'h30 + k);
      else if (k == 5)   step(0, 1, 1, 2'd2, '0);
      else if (k == 147) step(0, 1, 0, 2'd2, 32'h2);
      else               step(0, 0, 1, 2'd0, '0);
      if (k >= 1) begin
        exp_d = 8'h30 + 8'((k - 1) / 36 > 3 ? 3 : (k - 1) / 36);
        total++;
        if (lcd_data !== exp_d)
          $display("FAIL fifo_data k=%0d got %h required %h", k, lcd_data, exp_d);
        else passed++;
        total++;
        if (busy !== (k < 1 + 4 * 36))
          $display("FAIL fifo_busy k=%0d got %b required %b", k, busy, k < 145);
        else passed++;
      end
      if (k == 5) begin
        total++;
        if (bus.readdata !== 32'h3)
          $display("FAIL fifo_status got %h required 3", bus.readdata);
        else passed++;
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    for (int k = 0; k <= 10; k++) begin
      if (k <= 2)       step(0, 1, 0, 2'd1, 32'h55 + k);
      else if (k == 6)  step(1, 0, 1, 2'd0, '0);
      else if (k == 10) step(0, 1, 1, 2'd2, '0);
      else              step(0, 0, 1, 2'd0, '0);
      if (k == 5) begin
        total++;
        if (lcd_en !== 1'b1)
          $display("FAIL midrst_pulse got en=%b required 1", lcd_en);
        else passed++;
      end
      if (k >= 6) begin
        total++;
        if ({lcd_data, lcd_rs, lcd_en, busy} !== 11'h0)
          $display("FAIL midrst_out k=%0d got data=%h rs=%b en=%b busy=%b required all 0",
                   k, lcd_data, lcd_rs, lcd_en, busy);
        else passed++;
      end
      if (k == 10) begin
        total++;
        if (bus.readdata !== 32'h0)
          $display("FAIL midrst_status got %h required 0", bus.readdata);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    int          pct;
    int          r;
    logic [7:0]  b;
    logic [8:0]  mo;
    logic [1:0]  ad;
    for (int i = 0; i < 2400; i++) begin
      if (i % 200 == 0) pct = (i / 200 % 3 == 0) ? 3 : (i / 200 % 3 == 1) ? 10 : 40;
      r  = $urandom_range(0, 99);
      ad = 2'($urandom_range(0, 1));
      b  = 8'($urandom);
      if (ad == 2'd0 && $urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 3));
      if ($urandom_range(0, 599) == 0)
        step(1, 0, 1, 2'd0, '0);
      else if (r < pct)
        step(0, 1, 0, ad, {24'($urandom), b});
      else if (r < pct + 4)
        step(0, 1, 0, 2'($urandom_range(2, 3)), 32'($urandom));
      else if (r < pct + 25)
        step(0, 1, 1, 2'($urandom_range(0, 3)), '0);
      else
        step(0, 0, 1, 2'($urandom_range(0, 3)), '0);
      mo = m_out(cyc);
      total++;
      if ({lcd_rs, lcd_data} !== mo)
        $display("FAIL rand_bus cyc=%0d got rs=%b data=%h required rs=%b data=%h",
                 cyc, lcd_rs, lcd_data, mo[8], mo[7:0]);
      else passed++;
      total++;
      if (lcd_en !== m_en(cyc))
        $display("FAIL rand_en cyc=%0d got %b required %b", cyc, lcd_en, m_en(cyc));
      else passed++;
      total++;
      if (busy !== m_busy(cyc))
        $display("FAIL rand_busy cyc=%0d got %b required %b", cyc, busy, m_busy(cyc));
      else passed++;
      total++;
      if (bus.readdata !== m_rd)
        $display("FAIL rand_readdata cyc=%0d got %h required %h", cyc, bus.readdata, m_rd);
      else passed++;
      total++;
      if (lcd_rw !== 1'b0)
        $display("FAIL rand_rw cyc=%0d got %b required 0", cyc, lcd_rw);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_byte("instr38", 2'd0, 8'h38, NORM);
    test_byte("data41", 2'd1, 8'h41, NORM);
    test_byte("clear01", 2'd0, 8'h01, CLR);
    test_byte("instr80", 2'd0, 8'h80, NORM);
    test_byte("home03", 2'd0, 8'h03, CLR);
    test_byte("data01", 2'd1, 8'h01, NORM);
`ifndef NIOS_LCD_CTRL_FIFO_EN
    test_overflow();
`else
    test_fifo_overflow();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
